// File: rtl/apb_simple_timer_pkg.sv
// Shared constants and types for the APB simple timer: register map,
// CFG field layout and reset values.
package apb_simple_timer_pkg;

  localparam int DEF_CNT_W   = 32;
  localparam int DEF_PRESC_W = 8;
  localparam int DEF_ADDR_W  = 12;

  // Byte offsets of the four mapped registers.
  localparam logic [DEF_ADDR_W-1:0] OFF_CFG  = 12'h000;
  localparam logic [DEF_ADDR_W-1:0] OFF_CNT  = 12'h004;
  localparam logic [DEF_ADDR_W-1:0] OFF_CMP  = 12'h008;
  localparam logic [DEF_ADDR_W-1:0] OFF_STAT = 12'h00C;

  // Word index decoded from paddr[3:2].
  typedef enum logic [1:0] {
    REG_CFG  = 2'd0,
    REG_CNT  = 2'd1,
    REG_CMP  = 2'd2,
    REG_STAT = 2'd3
  } reg_e;

  // CFG field bit positions.
  localparam int CFG_EN_BIT       = 0;
  localparam int CFG_ONE_SHOT_BIT = 1;
  localparam int CFG_IRQ_EN_BIT   = 2;
  localparam int CFG_PRESC_LSB    = 8;
  localparam int STAT_MATCH_BIT   = 0;

  typedef struct packed {
    logic [DEF_PRESC_W-1:0] presc;
    logic                   irq_en;
    logic                   one_shot;
    logic                   en;
  } cfg_t;

  localparam cfg_t                 CFG_RESET = '0;
  localparam logic [DEF_CNT_W-1:0] CNT_RESET = '0;
  localparam logic [DEF_CNT_W-1:0] CMP_RESET = '0;

  // Bus word -> CFG fields; unlisted bits are dropped.
  function automatic cfg_t cfg_unpack(input logic [DEF_CNT_W-1:0] word);
    cfg_t c;
    c.en       = word[CFG_EN_BIT];
    c.one_shot = word[CFG_ONE_SHOT_BIT];
    c.irq_en   = word[CFG_IRQ_EN_BIT];
    c.presc    = word[CFG_PRESC_LSB +: DEF_PRESC_W];
    return c;
  endfunction

  // CFG fields -> bus word; unlisted bits read as 0.
  function automatic logic [DEF_CNT_W-1:0] cfg_pack(input cfg_t c);
    logic [DEF_CNT_W-1:0] word;
    word                               = '0;
    word[CFG_EN_BIT]                   = c.en;
    word[CFG_ONE_SHOT_BIT]             = c.one_shot;
    word[CFG_IRQ_EN_BIT]               = c.irq_en;
    word[CFG_PRESC_LSB +: DEF_PRESC_W] = c.presc;
    return word;
  endfunction

endpackage

// File: rtl/apb_simple_timer_if.sv
// APB3 bus bundle between a master (bench/interconnect) and the timer.
interface apb_simple_timer_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_simple_timer_core.sv
// Timer datapath: prescaler, up-counter, compare and match detection.
// The register file owns en/match; this block reports when to set match
// and when a one-shot run must drop en.
module apb_simple_timer_core
  import apb_simple_timer_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               one_shot,
  input  logic [PRESC_W-1:0] presc,
  input  logic [CNT_W-1:0]   cmp,
  input  logic               cnt_load,
  input  logic [CNT_W-1:0]   cnt_wdata,
  output logic [CNT_W-1:0]   cnt,
  output logic               match_set,
  output logic               stop
);

  logic [PRESC_W-1:0] pcnt;
  logic               tick;
  logic               cnt_hit;

  assign tick    = en && (pcnt == presc);
  assign cnt_hit = (cnt == cmp);

  // A CNT write swallows the tick, so no match can come from that cycle.
  assign match_set = tick && !cnt_load && cnt_hit;
  assign stop      = match_set && one_shot;

  // Prescaler and counter state; a CNT write restarts the prescale period.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses <= so every register samples pre-edge values.
    if (reset) begin
      pcnt <= '0;
      cnt  <= CNT_RESET;
    end else if (cnt_load) begin
      pcnt <= '0;
      cnt  <= cnt_wdata;
    end else if (en) begin
      if (tick) begin
        pcnt <= '0;
        cnt  <= cnt_hit ? '0 : cnt + CNT_W'(1);
      end else begin
        pcnt <= pcnt + PRESC_W'(1);
      end
    end
  end

endmodule

// File: rtl/apb_simple_timer.sv
// APB simple timer top: zero-wait-state APB3 slave, register file and
// probe outputs around the timer core.
module apb_simple_timer
  import apb_simple_timer_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int PRESC_W = DEF_PRESC_W,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  apb_simple_timer_if.slave   apb,
  output logic                irq_o,
  output logic                match_o,
  output logic [CNT_W-1:0]    cnt_o
);

  cfg_t             cfg;
  logic [CNT_W-1:0] cmp;
  logic             match;
  logic [CNT_W-1:0] cnt;
  logic             match_set;
  logic             stop;

  logic access;
  logic unmapped;
  logic wr_ok;
  logic rd_ok;
  reg_e sel;
  logic wr_cfg, wr_cnt, wr_cmp, wr_stat;
  logic unused_addr_lsbs;

  assign access   = apb.psel && apb.penable;
  assign unmapped = |apb.paddr[ADDR_W-1:4];
  assign sel      = reg_e'(apb.paddr[3:2]);
  assign wr_ok    = access && apb.pwrite && !unmapped;
  assign rd_ok    = access && !apb.pwrite && !unmapped;

  assign wr_cfg  = wr_ok && (sel == REG_CFG);
  assign wr_cnt  = wr_ok && (sel == REG_CNT);
  assign wr_cmp  = wr_ok && (sel == REG_CMP);
  assign wr_stat = wr_ok && (sel == REG_STAT);

  // Byte lanes within a word are not decoded.
  assign unused_addr_lsbs = ^apb.paddr[1:0];

  assign apb.pready  = access;
  assign apb.pslverr = access && unmapped;

  assign irq_o   = match && cfg.irq_en;
  assign match_o = match;
  assign cnt_o   = cnt;

  // CFG: a bus write beats the one-shot auto-clear of en.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg <= CFG_RESET;
    end else if (wr_cfg) begin
      cfg <= cfg_unpack(apb.pwdata);
    end else if (stop) begin
      cfg.en <= 1'b0;
    end
  end

  // CMP: the core compares against the value held before this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmp <= CMP_RESET;
    end else if (wr_cmp) begin
      cmp <= apb.pwdata;
    end
  end

  // Sticky match flag: a new match outranks a write-1-to-clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      match <= 1'b0;
    end else if (match_set) begin
      match <= 1'b1;
    end else if (wr_stat && apb.pwdata[STAT_MATCH_BIT]) begin
      match <= 1'b0;
    end
  end

  // Read mux: data only during a mapped read access phase, else 0.
  always_comb begin
    // NOTE: default assigned first so no path leaves prdata unassigned (no latch).
    apb.prdata = '0;
    if (rd_ok) begin
      unique case (sel)
        REG_CFG:  apb.prdata = cfg_pack(cfg);
        REG_CNT:  apb.prdata = cnt;
        REG_CMP:  apb.prdata = cmp;
        REG_STAT: apb.prdata[STAT_MATCH_BIT] = match;
        default:  apb.prdata = '0;
      endcase
    end
  end

  apb_simple_timer_core #(
    .CNT_W   (CNT_W),
    .PRESC_W (PRESC_W)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .en        (cfg.en),
    .one_shot  (cfg.one_shot),
    .presc     (cfg.presc),
    .cmp       (cmp),
    .cnt_load  (wr_cnt),
    .cnt_wdata (apb.pwdata),
    .cnt       (cnt),
    .match_set (match_set),
    .stop      (stop)
  );

endmodule

// File: tb/tb_apb_simple_timer.sv
// Directed bench for apb_simple_timer with hand-computed expectations.
module tb_apb_simple_timer;

  logic        clk;
  logic        reset;
  logic        irq_o;
  logic        match_o;
  logic [31:0] cnt_o;

  int n_checks = 0;
  int n_pass   = 0;

  apb_simple_timer_if #(.ADDR_W(12), .DATA_W(32)) apb ();

  apb_simple_timer #(.CNT_W(32), .PRESC_W(8), .ADDR_W(12)) dut (
    .clk     (clk),
    .reset   (reset),
    .apb     (apb),
    .irq_o   (irq_o),
    .match_o (match_o),
    .cnt_o   (cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Setup phase, access phase, commit on the third edge; returns 1ns after it.
  task automatic apb_write(input logic [11:0] addr, input logic [31:0] data,
                           output logic err);
    @(posedge clk); #1;
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
    apb.paddr = addr; apb.pwdata = data;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    #1 err = apb.pslverr;
    @(posedge clk); #1;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] addr, output logic [31:0] data,
                          output logic err, output logic rdy);
    @(posedge clk); #1;
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = addr;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    #1;
    data = apb.prdata; err = apb.pslverr; rdy = apb.pready;
    @(posedge clk); #1;
    apb.psel = 1'b0; apb.penable = 1'b0;
  endtask

  logic [31:0] rd;
  logic        err;
  logic        rdy;
  logic [11:0] reg_addr [4];

  initial begin
    reg_addr[0] = 12'h000; reg_addr[1] = 12'h004;
    reg_addr[2] = 12'h008; reg_addr[3] = 12'h00C;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    apb.paddr = '0; apb.pwdata = '0;
    do_reset();

    // Reset state of outputs and all registers.
    check("rst_irq", {31'b0, irq_o}, 32'h0);
    check("rst_match", {31'b0, match_o}, 32'h0);
    check("rst_cnt", cnt_o, 32'h0);
    for (int i = 0; i < 4; i++) begin
      apb_read(reg_addr[i], rd, err, rdy);
      check($sformatf("rst_rd%0d_data", i), rd, 32'h0);
      check($sformatf("rst_rd%0d_rdy", i), {31'b0, rdy}, 32'h1);
      check($sformatf("rst_rd%0d_err", i), {31'b0, err}, 32'h0);
    end

    // Free-running compare: CMP=3, presc=0, en+irq_en.
    do_reset();
    apb_write(12'h008, 32'd3, err);
    apb_write(12'h000, 32'h5, err);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      check($sformatf("run_cnt%0d", i), cnt_o, 32'(i % 4));
      check($sformatf("run_match%0d", i), {31'b0, match_o}, (i >= 4) ? 32'h1 : 32'h0);
      check($sformatf("run_irq%0d", i), {31'b0, irq_o}, (i >= 4) ? 32'h1 : 32'h0);
    end
    apb_write(12'h00C, 32'h1, err);
    check("w1c_cnt", cnt_o, 32'd3);
    check("w1c_match", {31'b0, match_o}, 32'h0);
    check("w1c_irq", {31'b0, irq_o}, 32'h0);
    @(posedge clk); #1;
    check("rematch", {31'b0, irq_o}, 32'h1);

    // One-shot with prescaler 2 and CMP=1.
    do_reset();
    apb_write(12'h008, 32'd1, err);
    apb_write(12'h000, 32'h0203, err);
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      check($sformatf("os_cnt%0d", i), cnt_o, (i >= 3 && i < 6) ? 32'd1 : 32'd0);
      check($sformatf("os_match%0d", i), {31'b0, match_o}, (i >= 6) ? 32'h1 : 32'h0);
    end
    apb_read(12'h000, rd, err, rdy);
    check("os_cfg_en_cleared", rd, 32'h0202);
    check("os_cnt_hold", cnt_o, 32'd0);
    check("os_no_irq", {31'b0, irq_o}, 32'h0);

    // Wrap from all-ones without a match.
    do_reset();
    apb_write(12'h004, 32'hFFFF_FFFF, err);
    apb_write(12'h008, 32'h10, err);
    apb_write(12'h000, 32'h1, err);
    check("wrap_pre", cnt_o, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    check("wrap_cnt", cnt_o, 32'h0);
    check("wrap_match", {31'b0, match_o}, 32'h0);
    @(posedge clk); #1;
    check("wrap_next", cnt_o, 32'h1);

    // W1C commits on the very edge a new match is set; CNT write in a tick cycle.
    do_reset();
    apb_write(12'h008, 32'd3, err);
    apb_write(12'h000, 32'h1, err);
    @(posedge clk);
    apb_write(12'h00C, 32'h1, err);
    check("w1c_vs_set_match", {31'b0, match_o}, 32'h1);
    check("w1c_vs_set_cnt", cnt_o, 32'h0);
    apb_write(12'h004, 32'h100, err);
    check("cnt_wr_wins", cnt_o, 32'h100);
    @(posedge clk); #1;
    check("cnt_wr_resume", cnt_o, 32'h101);

    // Unmapped offsets: error response, zero data, no side effects.
    do_reset();
    apb_write(12'h008, 32'h55, err);
    check("map_wr_err", {31'b0, err}, 32'h0);
    apb_write(12'h010, 32'hFFFF_FFFF, err);
    check("unm010_wr_err", {31'b0, err}, 32'h1);
    apb_read(12'h010, rd, err, rdy);
    check("unm010_rd_data", rd, 32'h0);
    check("unm010_rd_err", {31'b0, err}, 32'h1);
    apb_write(12'h018, 32'hAA, err);
    check("unm018_wr_err", {31'b0, err}, 32'h1);
    apb_write(12'hFFC, 32'h1, err);
    check("unmFFC_wr_err", {31'b0, err}, 32'h1);
    apb_read(12'hFFC, rd, err, rdy);
    check("unmFFC_rd_data", rd, 32'h0);
    check("unmFFC_rd_err", {31'b0, err}, 32'h1);
    apb_read(12'h008, rd, err, rdy);
    check("unm_cmp_kept", rd, 32'h55);
    apb_read(12'h000, rd, err, rdy);
    check("unm_cfg_kept", rd, 32'h0);
    check("unm_cnt_idle", cnt_o, 32'h0);

    // Reset asserted during a read access phase while counting.
    do_reset();
    apb_write(12'h008, 32'd2, err);
    apb_write(12'h000, 32'h5, err);
    repeat (5) @(posedge clk);
    #1;
    check("mid_pre_match", {31'b0, match_o}, 32'h1);
    check("mid_pre_cnt", cnt_o, 32'd2);
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = 12'h004;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_cnt", cnt_o, 32'h0);
    check("mid_match", {31'b0, match_o}, 32'h0);
    check("mid_irq", {31'b0, irq_o}, 32'h0);
    check("mid_prdata", apb.prdata, 32'h0);
    check("mid_pslverr", {31'b0, apb.pslverr}, 32'h0);
    apb.psel = 1'b0; apb.penable = 1'b0;
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
